// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: expands a 128-bit key into 44 round-key
// words, one 32-bit word per clock, with a start/busy/done handshake.
module key_expansion_seq (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [0:127]  key,
    output logic [0:1407] words,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // AES forward S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for round r = i/4 (1..10); other values never occur.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t      state, state_next;
    logic [5:0]  i, i_next;
    logic        busy_next, done_next;
    logic        load, write;

    // Bit offsets of w[i], w[i-1], w[i-4] (32*index)
    logic [10:0] idx_cur, idx_prev, idx_back;
    logic [31:0] w_prev, w_back, rot, sub, temp, w_new;

    assign idx_cur  = {i, 5'd0};
    assign idx_prev = {i - 6'd1, 5'd0};
    assign idx_back = {i - 6'd4, 5'd0};

    // Word datapath: temp from w[i-1], XOR with w[i-4]
    always_comb begin
        w_prev = words[idx_prev +: 32];
        w_back = words[idx_back +: 32];
        rot    = {w_prev[23:0], w_prev[31:24]};
        sub    = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        temp   = (i[1:0] == 2'd0) ? (sub ^ {rcon(i[5:2]), 24'h0}) : w_prev;
        w_new  = w_back ^ temp;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        i_next     = i;
        busy_next  = busy;
        done_next  = done;
        load       = 1'b0;
        write      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    i_next     = 6'd4;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                write  = 1'b1;
                i_next = i + 6'd1;
                if (i == 6'd43) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= 6'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            i     <= i_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Key schedule storage: load key and clear the rest, then fill one word per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words <= '0;
        end else if (load) begin
            words <= {key, 1280'd0};
        end else if (write) begin
            words[idx_cur +: 32] <= w_new;
        end
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: stimulus pushes expected schedules into a
// queue, a monitor pops and compares whenever done rises.
module tb_key_expansion_seq;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [0:127]  key;
    logic [0:1407] words;
    logic          busy;
    logic          done;

    key_expansion_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .words (words),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    localparam logic [0:127] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK10_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        string        name;
        logic [31:0]  w4;
        logic [127:0] rk10;
        int           start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, " words"}, 128'(|words), 128'd0);
        check({nm, " busy"},  128'(busy),   128'd0);
        check({nm, " done"},  128'(done),   128'd0);
    endtask

    // Called at a negedge; pulses start for one cycle, returns at the next negedge
    task automatic do_start(input logic [0:127] k, input bit push, input string nm,
                            input logic [31:0] w4, input logic [127:0] rk10);
        exp_t e;
        start = 1'b1;
        key   = k;
        if (push) begin
            e.name = nm; e.w4 = w4; e.rk10 = rk10; e.start_cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s timeout: done=%0b after %0d cycles, wanted 1", nm, done, n);
        end
    endtask

    // Monitor: on each rising done, pop the expected schedule and compare
    logic done_q = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    n_cmp = n_cmp + 1;
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, want no completion", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, " w4"},      128'(words[128 +: 32]), 128'(e.w4));
                    check({e.name, " rk10"},    words[1280 +: 128],     e.rk10);
                    check({e.name, " latency"}, 128'(cyc - e.start_cyc), 128'd40);
                    check({e.name, " busy_cycles"}, 128'(busy_cnt),     128'd40);
                end
                busy_cnt = 0;
            end
            done_q = done;
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        #1;
        check_zero_outputs("por");

        // start coincident with reset is lost
        @(negedge clk);
        start = 1'b1;
        key   = KEY_A;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("start_in_reset busy", 128'(busy), 128'd0);
        check("start_in_reset done", 128'(done), 128'd0);

        // asynchronous reset from a random point of a run
        do_start(KEY_C, 1'b1, "aborted", 32'h0, 128'h0);
        repeat ($urandom_range(3, 30)) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_zero_outputs("rand_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 App. A
        do_start(KEY_A, 1'b1, "appA", 32'ha0fafe17, RK10_A);
        @(negedge clk);
        check("appA early w4", 128'(words[128 +: 32]), 128'h00000000_00000000_00000000_a0fafe17);
        wait_done("appA");
        repeat (3) @(negedge clk);

        // start during busy is ignored
        do_start(KEY_A, 1'b1, "appA_busy", 32'ha0fafe17, RK10_A);
        repeat (19) @(negedge clk);
        do_start(KEY_C, 1'b0, "", 32'h0, 128'h0);
        wait_done("appA_busy");
        repeat (2) @(negedge clk);

        // FIPS-197 App. C.1
        do_start(KEY_C, 1'b1, "c1", 32'hd6aa74fd, RK10_C);
        wait_done("c1");
        repeat (2) @(negedge clk);

        // reset mid-run, then a fresh C.1 run
        do_start(KEY_A, 1'b1, "aborted2", 32'h0, 128'h0);
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_start(KEY_C, 1'b1, "c1_after_reset", 32'hd6aa74fd, RK10_C);
        wait_done("c1_after_reset");

        // back-to-back: start in the first DONE cycle
        do_start(KEY_A, 1'b1, "b2b_appA", 32'ha0fafe17, RK10_A);
        check("b2b done", 128'(done), 128'd0);
        check("b2b busy", 128'(busy), 128'd1);
        check("b2b w4_43 clear", 128'(|words[128 +: 1280]), 128'd0);
        check("b2b key words", words[0 +: 128], 128'(KEY_A));
        wait_done("b2b_appA");
        repeat (3) @(negedge clk);

        check("queue drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Sequential AES-128 key schedule that expands a 128-bit cipher key into the 44-word (1408-bit) round-key bus consumed by the cipher core's `words` input. It sits directly upstream of the cipher core and computes one 32-bit word per clock. A start/done handshake tells the cipher when all 11 round keys are valid, replacing a purely combinational expansion with a small, timing-friendly datapath.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10, 44 words.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  pulse; requests expansion of `key`. Sampled only in IDLE or DONE.
- `key`  input  [0:127]  cipher key, bit 0 = MSB. Sampled on the accepted `start` edge only.
- `words`  output  [0:1407]  expanded key, registered.
  - Word w[i] occupies bits [32*i +: 32].
  - Round key r = bits [128*r +: 128].
- `busy`  output  1  high while expansion is in progress.
- `done`  output  1  level; high when `words` holds a complete, valid schedule.

## Operation
- FSM states: IDLE, EXPAND, DONE. Word index `i` is 6 bits, range 4..43.
- Reset (async):
  - state=IDLE, i=0.
  - `words`=0, `busy`=0, `done`=0.
- IDLE or DONE, with `start`=1:
  - w[0..3] <= `key`.
  - w[4..43] <= 0.
  - i <= 4, `busy` <= 1, `done` <= 0, state -> EXPAND.
- EXPAND, each cycle:
  - w[i] <= w[i-4] ^ temp.
  - If i%4==0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/4], 24'h0}.
  - Otherwise: temp = w[i-1].
  - RotWord rotates left by one byte. SubWord applies the AES forward S-box to each of the 4 bytes (internal ROM/case function, 4 instances).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - i <= i+1.
- On the cycle that writes i=43: state -> DONE, `busy` <= 0, `done` <= 1.
- DONE holds `words` and `done`=1 indefinitely until the next accepted `start`.
- `start` while in EXPAND is ignored. No restart, no queueing.
- `key` changes after the `start` edge have no effect on the running expansion.
- All arithmetic is XOR. No carries; widths are exact 32-bit.

## Timing
- Latency: `start` sampled at edge E0.
  - w[0..3] valid after E0.
  - w[4] is written at E1; w[k] is written at edge E(k-3).
  - w[43] is written at E40, together with `done`=1 and `busy`=0.
  - Total: 40 cycles from `start` edge to `done`.
- `busy` is high from E0 through E39, i.e. exactly 40 cycles.
- Back-to-back: `start` in the first DONE cycle is accepted. `done` drops after that edge, and w[4..43] clear in the same edge.
- `start` coincident with reset assertion: reset wins. State stays IDLE; `start` is lost.
- Reset asserted mid-EXPAND: all outputs return to 0 immediately (asynchronously). No partial schedule remains visible.
- The downstream cipher must only sample `words` while `done`=1.

## Test plan
- Reset check: assert `rst` with random prior state.
  - Required: `words`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- FIPS-197 App. A key: `key`=2b7e151628aed2a6abf7158809cf4f3c, one-cycle `start`.
  - w[4]=a0fafe17.
  - Bits [1280+:128] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` rises exactly 40 edges after `start`; `busy` is high for exactly 40 cycles.
- FIPS-197 App. C.1 key: `key`=000102030405060708090a0b0c0d0e0f.
  - w[4]=d6aa74fd.
  - Round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Start during busy: re-pulse `start` with a different key at cycle 20 of the App. A run.
  - Required: ignored; final result still ends d014f9a8…b6630ca6, `done` at cycle 40.
- Reset mid-run: assert `rst` at cycle 15, release it, then `start` with the C.1 key.
  - Required: outputs 0 while reset is asserted, then the correct C.1 schedule with `done` 40 cycles after the new `start`.
- Back-to-back: `start` with the App. A key in the first DONE cycle after a C.1 run.
  - Required: `done` falls and w[4..43] read 0 the next cycle, then the App. A schedule completes 40 cycles later.
